// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encodings and constants for the pipeline sequencer
package pipe_ctrl_pkg;

   // Sequencer states; encodings are fixed so debug tooling can decode them.
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_MC_WAIT = 2'd2
   } pipe_state_t;

   // Instruction injected by the IF/ID and ID/EX registers when flushed (addi x0, x0, 0).
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CNT_W  = 32;

   // A jump or an EX hold request both redirect the front end.
   function automatic logic jump_request(input logic jump_en, input logic hold_en);
      return jump_en | hold_en;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - request inputs and control/status outputs of the pipeline sequencer
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic              ex_jump_en;
   logic [ADDR_W-1:0] ex_jump_addr;
   logic              ex_hold_en;
   logic              ex_mc_req;
   logic              mc_done;
   logic              bus_stall_req;

   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_addr;
   logic              pc_hold;
   logic              if_id_hold;
   logic              id_ex_hold;
   logic              if_id_flush;
   logic              id_ex_flush;
   logic              mc_start;
   logic              mc_abort;
   logic              err;
   logic [CNT_W-1:0]  stall_cycles;
   logic [CNT_W-1:0]  flush_events;

   // Sequencer side: consumes requests, drives pipeline control.
   modport master (
      input  ex_jump_en, ex_jump_addr, ex_hold_en, ex_mc_req, mc_done, bus_stall_req,
      output pc_load, pc_load_addr, pc_hold, if_id_hold, id_ex_hold,
             if_id_flush, id_ex_flush, mc_start, mc_abort, err,
             stall_cycles, flush_events
   );

   // Pipeline side: issues requests, obeys pipeline control.
   modport slave (
      output ex_jump_en, ex_jump_addr, ex_hold_en, ex_mc_req, mc_done, bus_stall_req,
      input  pc_load, pc_load_addr, pc_hold, if_id_hold, id_ex_hold,
             if_id_flush, id_ex_flush, mc_start, mc_abort, err,
             stall_cycles, flush_events
   );

endinterface

// File: rtl/pipe_ctrl_perf_cnt.sv
// rtl/pipe_ctrl_perf_cnt.sv - 32-bit wrapping event counter with enable
module pipe_ctrl_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [31:0] count
);

   logic [31:0] cnt_q;
   logic [31:0] cnt_d;

   // Count one per enabled cycle; natural overflow gives the wrap at 2^32.
   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // Counter register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: jumps/flush, multi-cycle waits, bus stalls, watchdog
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MC_TIMEOUT   = 64
) (
   input  logic         clk,
   input  logic         rst,
   pipe_ctrl_if.master  pif
);

   // Remaining FLUSH-state cycles after the jump cycle, minus one (down-counter terminal is 0).
   localparam logic [1:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

   localparam int unsigned      WAIT_W    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   pipe_state_t       state_q, state_d;
   logic [1:0]        flush_cnt_q, flush_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;

   logic              jump_req;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_load_addr;
   logic              hold_all;
   logic              flush_all;
   logic              mc_start;
   logic              mc_abort;
   logic              jump_taken;

   assign jump_req = jump_request(pif.ex_jump_en, pif.ex_hold_en);

   // Next-state and zero-latency control outputs; holds and flushes are mutually exclusive by construction.
   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      err_d        = err_q;
      pc_load      = 1'b0;
      pc_load_addr = '0;
      hold_all     = 1'b0;
      flush_all    = 1'b0;
      mc_start     = 1'b0;
      mc_abort     = 1'b0;
      jump_taken   = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (jump_req) begin
               pc_load      = 1'b1;
               pc_load_addr = pif.ex_jump_addr;
               flush_all    = 1'b1;
               jump_taken   = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FLUSH_LOAD;
               end
            end else if (pif.ex_mc_req) begin
               mc_start   = 1'b1;
               hold_all   = 1'b1;
               state_d    = ST_MC_WAIT;
               wait_cnt_d = '0;
            end else if (pif.bus_stall_req) begin
               hold_all = 1'b1;
            end
         end

         ST_FLUSH: begin
            // EX holds a bubble here, so every request input is deliberately ignored.
            flush_all = 1'b1;
            if (flush_cnt_q == 2'd0) begin
               state_d = ST_RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - 2'd1;
            end
         end

         ST_MC_WAIT: begin
            if (pif.mc_done) begin
               state_d = ST_RUN;
            end else if (wait_cnt_q == WAIT_LAST) begin
               mc_abort = 1'b1;
               err_d    = 1'b1;
               state_d  = ST_RUN;
            end else begin
               hold_all   = 1'b1;
               wait_cnt_d = wait_cnt_q + WAIT_ONE;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State, counters and the sticky error flag; err is cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= 2'd0;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
      end
   end

   pipe_ctrl_perf_cnt u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (hold_all),
      .count (pif.stall_cycles)
   );

   pipe_ctrl_perf_cnt u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (jump_taken),
      .count (pif.flush_events)
   );

   assign pif.pc_load      = pc_load;
   assign pif.pc_load_addr = pc_load_addr;
   assign pif.pc_hold      = hold_all;
   assign pif.if_id_hold   = hold_all;
   assign pif.id_ex_hold   = hold_all;
   assign pif.if_id_flush  = flush_all;
   assign pif.id_ex_flush  = flush_all;
   assign pif.mc_start     = mc_start;
   assign pif.mc_abort     = mc_abort;
   assign pif.err          = err_q;

endmodule
